// File: rtl/router_pkg.sv
// Shared router constants: byte width, buffer depth, header length field and derived widths.
package router_pkg;

    localparam int DATA_W  = 8;
    localparam int DEPTH   = 16;
    localparam int LEN_MSB = 7;
    localparam int LEN_LSB = 2;
    localparam int PTR_W   = $clog2(DEPTH) + 1;
    // Payload length plus one parity byte needs one bit more than the length field.
    localparam int CNT_W   = LEN_MSB - LEN_LSB + 2;

endpackage

// File: rtl/router_fifo_ram.sv
// Entry storage for one output buffer: synchronous write, asynchronous read, no reset.
module router_fifo_ram #(
    parameter int DATA_W = router_pkg::DATA_W,
    parameter int DEPTH  = router_pkg::DEPTH
) (
    input  logic                     clk,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_waddr,
    input  logic [DATA_W:0]          i_wdata,
    input  logic [$clog2(DEPTH)-1:0] i_raddr,
    output logic [DATA_W:0]          o_rdata
);

    logic [DATA_W:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/router_fifo.sv
// Per-destination packet byte buffer with header marking; registered read data, 1-cycle latency.
// Writes while full and reads while empty are dropped; data_out clears once a packet has drained.
module router_fifo #(
    parameter int DATA_W = router_pkg::DATA_W,
    parameter int DEPTH  = router_pkg::DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              soft_rst,
    input  logic              write_enb,
    input  logic              read_enb,
    input  logic              lfd_state,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              full,
    output logic              empty
);

    import router_pkg::*;

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0]    PTR_ONE  = PW'(1);
    localparam logic [PW-1:0]    WRAP_MSK = {1'b1, {AW{1'b0}}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [PW-1:0]     r_wr_ptr;
    logic [PW-1:0]     r_rd_ptr;
    logic [CNT_W-1:0]  r_pkt_cnt;
    logic [DATA_W-1:0] r_data_out;

    logic [DATA_W:0]   w_rd_entry;
    logic [CNT_W-1:0]  w_hdr_len;
    logic              w_full;
    logic              w_empty;
    logic              w_wr_acc;
    logic              w_rd_acc;
    logic              w_ram_we;

    assign w_empty  = (r_wr_ptr == r_rd_ptr);
    assign w_full   = ((r_wr_ptr ^ r_rd_ptr) == WRAP_MSK);
    assign w_wr_acc = write_enb & ~w_full;
    assign w_rd_acc = read_enb & ~w_empty;
    // A flush cycle must not leave a stale write behind in the array.
    assign w_ram_we = w_wr_acc & ~soft_rst;

    router_fifo_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_ram_we),
        .i_waddr (r_wr_ptr[AW-1:0]),
        .i_wdata ({lfd_state, data_in}),
        .i_raddr (r_rd_ptr[AW-1:0]),
        .o_rdata (w_rd_entry)
    );

    assign w_hdr_len = {1'b0, w_rd_entry[LEN_MSB:LEN_LSB]} + CNT_ONE;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (soft_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_rd_acc) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
        end
    end

    // Counter tracks bytes left in the packet being drained; data_out idles at 0 between packets.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pkt_cnt  <= '0;
            r_data_out <= '0;
        end else if (soft_rst) begin
            r_pkt_cnt  <= '0;
            r_data_out <= '0;
        end else if (w_rd_acc) begin
            r_data_out <= w_rd_entry[DATA_W-1:0];
            if (w_rd_entry[DATA_W]) begin
                r_pkt_cnt <= w_hdr_len;
            end else if (r_pkt_cnt != '0) begin
                r_pkt_cnt <= r_pkt_cnt - CNT_ONE;
            end
        end else if (r_pkt_cnt == '0) begin
            r_data_out <= '0;
        end
    end

    assign data_out = r_data_out;
    assign full     = w_full;
    assign empty    = w_empty;

endmodule

// File: tb/tb_router_fifo.sv
// Randomized and directed bench for router_fifo against a queue-based packet buffer model.
module tb_router_fifo;

    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       soft_rst;
    logic       write_enb;
    logic       read_enb;
    logic       lfd_state;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       full;
    logic       empty;

    int n_checks = 0;
    int n_fail   = 0;

    logic [8:0] mq[$];
    int         m_cnt;
    logic [7:0] m_dout;

    router_fifo #(.DATA_W(8), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .soft_rst  (soft_rst),
        .write_enb (write_enb),
        .read_enb  (read_enb),
        .lfd_state (lfd_state),
        .data_in   (data_in),
        .data_out  (data_out),
        .full      (full),
        .empty     (empty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic m_reset();
        mq.delete();
        m_cnt  = 0;
        m_dout = 8'h00;
    endtask

    // One clock of stimulus; model follows the buffer rules, outputs compared at the falling edge.
    task automatic step(input logic we, input logic re, input logic lfd,
                        input logic [7:0] din, input logic sr);
        logic       m_full;
        logic       m_empty;
        logic [8:0] ent;
        write_enb = we;
        read_enb  = re;
        lfd_state = lfd;
        data_in   = din;
        soft_rst  = sr;
        @(posedge clk);
        if (sr) begin
            m_reset();
        end else begin
            m_full  = (mq.size() == DEPTH);
            m_empty = (mq.size() == 0);
            if (re && !m_empty) begin
                ent    = mq.pop_front();
                m_dout = ent[7:0];
                if (ent[8])
                    m_cnt = int'(ent[7:2]) + 1;
                else if (m_cnt > 0)
                    m_cnt = m_cnt - 1;
            end else if (m_cnt == 0) begin
                m_dout = 8'h00;
            end
            if (we && !m_full)
                mq.push_back({lfd, din});
        end
        @(negedge clk);
        write_enb = 1'b0;
        read_enb  = 1'b0;
        lfd_state = 1'b0;
        soft_rst  = 1'b0;
        chk("dout",  data_out, m_dout);
        chk("full",  full,  mq.size() == DEPTH);
        chk("empty", empty, mq.size() == 0);
        chk("cnt",   dut.r_pkt_cnt, m_cnt);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] pkt [5];
        logic [7:0] rd_val;
        pkt[0] = 8'h0D; pkt[1] = 8'hA1; pkt[2] = 8'hA2; pkt[3] = 8'hA3; pkt[4] = 8'h5C;

        rst = 1'b1; soft_rst = 1'b0; write_enb = 1'b0; read_enb = 1'b0;
        lfd_state = 1'b0; data_in = 8'h00;
        m_reset();
        #2;
        chk("rst_empty", empty, 1);
        chk("rst_full",  full,  0);
        chk("rst_dout",  data_out, 0);
        @(negedge clk);
        rst = 1'b0;

        // Single packet: header length 3 -> counter 4,3,2,1,0.
        for (int i = 0; i < 5; i++)
            step(1'b1, 1'b0, (i == 0), pkt[i], 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
            chk("pkt_byte", data_out, pkt[i]);
            chk("pkt_cnt",  dut.r_pkt_cnt, 4 - i);
        end
        step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        chk("pkt_idle", data_out, 0);

        // Asynchronous reset mid-packet, between clock edges.
        step(1'b1, 1'b0, 1'b1, 8'h0D, 1'b0);
        step(1'b1, 1'b0, 1'b0, 8'h11, 1'b0);
        step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        #1 rst = 1'b1;
        #1;
        chk("arst_empty", empty, 1);
        chk("arst_full",  full,  0);
        chk("arst_dout",  data_out, 0);
        #1 rst = 1'b0;
        m_reset();

        // Full boundary.
        for (int i = 0; i < DEPTH; i++)
            step(1'b1, 1'b0, 1'b0, 8'($urandom), 1'b0);
        chk("full_set", full, 1);
        step(1'b1, 1'b0, 1'b0, 8'hFF, 1'b0);
        chk("full_drop", full, 1);
        step(1'b1, 1'b1, 1'b0, 8'hEE, 1'b0);
        chk("full_rw", full, 0);
        for (int i = 0; i < DEPTH - 1; i++)
            step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);

        // Empty boundary.
        step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        chk("empty_rd_dout", data_out, 0);
        step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        chk("empty_rd_empty", empty, 1);
        step(1'b1, 1'b1, 1'b0, 8'h77, 1'b0);
        chk("empty_wr", empty, 0);
        step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        chk("empty_wr_byte", data_out, 8'h77);

        // Wrap-around at occupancy 5 with incrementing data.
        rd_val = 8'h00;
        for (int i = 0; i < 5; i++)
            step(1'b1, 1'b0, 1'b0, 8'(i), 1'b0);
        for (int i = 0; i < 40; i++) begin
            step(1'b1, 1'b1, 1'b0, 8'(i + 5), 1'b0);
            chk("wrap_ord", data_out, rd_val);
            chk("wrap_flags", {full, empty}, 2'b00);
            rd_val = rd_val + 8'h01;
        end
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
            chk("wrap_tail", data_out, rd_val);
            rd_val = rd_val + 8'h01;
        end

        // Soft reset mid-packet, with a write in the flush cycle.
        step(1'b1, 1'b0, 1'b1, 8'h15, 1'b0);
        for (int i = 0; i < 5; i++)
            step(1'b1, 1'b0, 1'b0, 8'(8'hB0 + i), 1'b0);
        step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        step(1'b1, 1'b0, 1'b0, 8'hEE, 1'b1);
        chk("srst_empty", empty, 1);
        chk("srst_dout",  data_out, 0);
        step(1'b1, 1'b0, 1'b1, 8'h09, 1'b0);
        step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        chk("srst_hdr", data_out, 8'h09);
        chk("srst_cnt", dut.r_pkt_cnt, 3);

        // Random traffic with occasional flushes.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0),
                 ($urandom_range(0, 5) == 0), 8'($urandom),
                 ($urandom_range(0, 39) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/router_fifo.md
# router_fifo

Per-destination output buffer of the 1x3 router. The synchronizer's `write_enb[i]`, `sft_rst_i`, and the router FSM's `lfd_state` drive three instances of this block. Each instance stores packet bytes with a header marker, reports `full`/`empty` back to the synchronizer, and presents bytes to its output port on `read_enb`. It also tracks each packet's length on the read side, so `data_out` is driven only while a packet is being drained.

## Interface
- `DATA_W`, default 8: byte width; the header carries the payload length in bits [7:2] and the address in bits [1:0].
- `DEPTH`, default 16: number of entries; must be a power of two and at least 4.
- `clk` input, 1: single clock; all state changes on the rising edge.
- `rst` input, 1: asynchronous, active-high reset.
- `soft_rst` input, 1: synchronous, active-high flush, driven by the synchronizer's timeout (`sft_rst_i`).
- `write_enb` input, 1: write request for `data_in` this cycle.
- `read_enb` input, 1: read request from the output port.
- `lfd_state` input, 1: marks the byte written this cycle as a packet header.
- `data_in` input, `DATA_W`: byte to store.
- `data_out` output, `DATA_W`: registered read data.
- `full` output, 1: no free entry.
- `empty` output, 1: no stored entry.

## Operation
- Each entry is `DATA_W+1` bits wide: {hdr flag, byte}. On an accepted write, the hdr flag is set to `lfd_state`.
- Write and read pointers are `$clog2(DEPTH)+1` bits; the MSB is a wrap bit.
  - `empty` = pointers equal.
  - `full` = pointers differ only in the MSB.
- Accepted write = `write_enb & ~full`. Accepted read = `read_enb & ~empty`. `full`/`empty` are the values before the edge.
- Write and read together:
  - When neither `full` nor `empty`: both are accepted.
  - When `full`: only the read is accepted.
  - When `empty`: only the write is accepted.
  - A write while `full` or a read while `empty` is dropped silently; no pointer moves and no error is flagged.
- Packet counter `pkt_cnt`, width 7 (`DATA_W-2+1`):
  - On an accepted read of an entry whose hdr flag is 1: load `byte[7:2] + 1` (payload plus parity).
  - On an accepted read of a non-header entry with `pkt_cnt` > 0: decrement.
  - Never decrements below 0.
- `data_out`:
  - On an accepted read: loaded with the stored byte.
  - Otherwise, when `pkt_cnt` == 0: cleared to 0.
  - Otherwise: held.
- Priority: `rst` > `soft_rst` > normal read/write.
  - `soft_rst` clears both pointers, `pkt_cnt` and `data_out` at the edge. Any write or read in that cycle is discarded.
  - Memory contents are not cleared by either reset.

## Timing
- Reset values: `data_out`=0, `full`=0, `empty`=1; pointers and `pkt_cnt` are 0.
- `full` and `empty` are combinational from the pointers. They change in the cycle after the accepted write or read edge.
- Read latency is 1 clock: a byte accepted at edge N appears on `data_out` after edge N.
- Write-to-readable latency is 1 clock: `empty` deasserts after the edge on which the first write is accepted.
- Full throughput: one write and one read per cycle, sustained.
- A header byte may be read in the same cycle as the last byte of the previous packet is written.
- Wrap-around: the pointer index wraps from `DEPTH-1` to 0 and the MSB toggles. Fill, drain, and refill across the wrap must behave the same as without the wrap.
- Asserting `rst` mid-packet returns all outputs to their reset values immediately, without waiting for the clock edge.
- Asserting `soft_rst` mid-packet takes effect at the next edge. `empty`=1 and `data_out`=0 in the following cycle.

## Structure
- Shared package `router_pkg`: `DATA_W`, `DEPTH`, `LEN_MSB`=7, `LEN_LSB`=2, and the derived pointer width. The FSM, synchronizer and FIFO all import these.
- One sub-module, `router_fifo_ram`: a `DEPTH` x (`DATA_W+1`) array with one synchronous write port and an asynchronous read port, with no reset.
- Pointers, flags, `pkt_cnt` and the `data_out` register stay in `router_fifo`.

## Test plan
- Reset: pulse `rst` with no clock edge → `empty`=1, `full`=0, `data_out`=0 immediately.
- Single packet: write header 0x0D with `lfd_state`=1 (length 3), then 0xA1, 0xA2, 0xA3, parity 0x5C. Read 5 bytes back-to-back → `data_out` shows 0x0D, 0xA1, 0xA2, 0xA3, 0x5C on consecutive cycles, and `pkt_cnt` goes 4, 3, 2, 1, 0. One idle cycle later, `data_out`=0.
- Full boundary: write 16 bytes → `full`=1 after the 16th edge. A 17th write is dropped. A simultaneous read and write while full → only the read is accepted, and `full` deasserts.
- Empty boundary: `read_enb`=1 while empty → pointers unchanged and `data_out` holds 0. A simultaneous write and read while empty → only the write is accepted, and `empty`=0 next cycle.
- Wrap-around: run 40 write/read pairs with an occupancy of 5, using incrementing data → the read order matches the write order exactly, with no spurious `full`/`empty`.
- Soft reset: after 6 bytes are written and 2 read, assert `soft_rst` for one cycle together with `write_enb` → next cycle `empty`=1, `data_out`=0, and a fresh header write is read back correctly.
